bcd8_to_bin: RTL
================

# bcd8_to_bin

Sequential converter from a two-digit packed BCD value (00–99) to a 7-bit binary value, using reverse double-dabble: one shift per clock, with a start/done handshake. It sits on the read side of the 8-bit decade up/down counters. It takes the counter's Q0–Q7 decade outputs and produces a binary count for comparators, address generators and register readback.

## Interface
Parameters: none. Width is fixed at two BCD digits.

Ports:
- CLK  input  1  system clock, all state on rising edge
- CS  input  1  synchronous active-high clear; one clock, reset is synchronous and active-high
- START  input  1  request conversion of D7..D0; sampled only in IDLE
- D0..D7  input  1 each  packed BCD; D3..D0 = units digit, D7..D4 = tens digit
- Q0..Q6  output  1 each  binary result, Q6 = MSB; registered
- BUSY  output  1  high while a conversion is in progress
- DONE  output  1  single-cycle pulse when Q0..Q6 become valid
- ERR  output  1  invalid BCD digit detected; see Configuration

## Operation
- States:
  - IDLE: BUSY=0, waits for START.
  - SHIFT: 8 iterations, BUSY=1.
  - FIN: one cycle, DONE=1, BUSY=0.
- Transitions:
  - IDLE→SHIFT when START=1. On that edge, latch {D7..D0} into the 8-bit BCD register, clear the 8-bit binary shift register, and set the iteration counter to 0.
  - SHIFT→SHIFT while counter < 7.
  - SHIFT→FIN on the edge where counter = 7.
  - FIN→IDLE unconditionally.
- Each SHIFT iteration, all on one edge:
  - Shift the 16-bit word {bcd, bin} right by 1. The BCD LSB enters the binary MSB.
  - Then, for each 4-bit digit of the shifted BCD part: if the digit is ≥ 8, subtract 3. Compute this on the post-shift value, combinationally, within the same edge.
  - Increment the counter.
- Result: after 8 iterations, bin[7:0] = 10·tens + units. Bit 7 is always 0 for valid input, and Q6..Q0 = bin[6:0].
- On entering FIN, copy Q6..Q0 from bin[6:0]. Q holds its value until the next FIN or CS.
- START while BUSY=1 or in FIN: ignored. No queuing.
- START held high continuously: a new conversion starts on the first IDLE cycle after FIN, so back-to-back conversions are spaced 10 cycles apart.
- D0..D7 are sampled only on the START-accept edge. Later changes to D have no effect.
- CS takes priority over everything, in any state. Next state is IDLE, with Q=0, BUSY=0, DONE=0, ERR=0, and all internal registers 0. A conversion in progress is abandoned and no DONE is produced.

## Timing
- Reset values: Q0..Q6=0, BUSY=0, DONE=0, ERR=0, state IDLE.
- Cycle-level sequence, with edge n being the edge that samples START=1 in IDLE:
  - Edge n: BUSY=1 from cycle n+1 onward.
  - Edges n+1 .. n+8: the eight shift iterations.
  - Edge n+8: state becomes FIN and Q is updated, with DONE=1 and BUSY=0 during cycle n+9.
  - Edge n+9: back to IDLE, and DONE returns to 0.
- Latency from the START-sample edge to DONE high is 9 clocks. The earliest next START sample is edge n+10.
- ERR is updated on the same edge as Q, at the transition into FIN. It holds until the next FIN or CS.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- BCD8_TO_BIN_CHECK_EN defined:
  - On the START-accept edge, flag whether either latched digit is > 9.
  - At FIN, ERR = flag. If the flag is set, Q6..Q0 = 0 instead of the algorithmic result.
  - DONE timing is unchanged.
- BCD8_TO_BIN_CHECK_EN undefined:
  - ERR is tied to 0 and no check logic is built.
  - Q for invalid digit codes is whatever the algorithm produces. The spec does not define it and the bench does not check it.

## Structure
- Package bcd8_to_bin_pkg holds:
  - the state encoding enum (IDLE, SHIFT, FIN)
  - ITER_LAST = 7
  - BCD_ADJ = 3
  - DIGIT_ADJ_THRESH = 8
  - MAX_DEC_DIGIT = 9
- Sub-module bcd_digit_adj: a combinational 4-bit cell, out = (in ≥ 8) ? in − 3 : in. It is instantiated twice, once for the tens digit and once for the units digit.
- Top level holds the FSM, the iteration counter, the shift registers, the output registers and the optional check.

## Test plan
- CS for 2 cycles, then idle → all outputs 0. START=1 with D=0x00 → DONE at n+9, Q=0, ERR=0.
- D=0x99 (99) → BUSY high for cycles n+1..n+8, DONE single pulse at n+9, Q=99 (1100011b). D=0x47 → Q=47.
- Sweep every valid code 0x00..0x99 with START held high → each DONE is 10 cycles apart and Q equals the decimal value.
- START at n, START pulsed again at n+3, and D changed at n+2 → only one DONE at n+9, and Q reflects the D sampled at n.
- START at n, CS at n+4 → BUSY=0 from n+5 and no DONE. A fresh START=0x12 then gives Q=12.
- With BCD8_TO_BIN_CHECK_EN defined: D=0x3A → DONE at n+9, ERR=1, Q=0. A following D=0x25 → ERR=0, Q=25.

Source files
------------

// File: rtl/bcd8_to_bin_pkg.sv
// Shared encodings and constants for the two-digit BCD to binary converter.
package bcd8_to_bin_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_e;

  localparam logic [2:0] ITER_LAST        = 3'd7;
  localparam logic [3:0] BCD_ADJ          = 4'd3;
  localparam logic [3:0] DIGIT_ADJ_THRESH = 4'd8;
  localparam logic [3:0] MAX_DEC_DIGIT    = 4'd9;

endpackage

// File: rtl/bcd8_to_bin_digit_adj.sv
// Reverse double-dabble digit correction: a digit of 8 or more after a right
// shift carried a half-decade across the boundary, so pull it back by 3.
module bcd_digit_adj
  import bcd8_to_bin_pkg::*;
(
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  assign out_o = (in_i >= DIGIT_ADJ_THRESH) ? (in_i - BCD_ADJ) : in_i;

endmodule

// File: rtl/bcd8_to_bin.sv
// Two-digit packed BCD to 7-bit binary, one shift per clock; DONE 9 clocks after START.
// Optional invalid-digit check enabled by defining BCD8_TO_BIN_CHECK_EN.
module bcd8_to_bin
  import bcd8_to_bin_pkg::*;
(
  input  logic CLK,
  input  logic CS,
  input  logic START,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic D4,
  input  logic D5,
  input  logic D6,
  input  logic D7,
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic Q4,
  output logic Q5,
  output logic Q6,
  output logic BUSY,
  output logic DONE,
  output logic ERR
);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [15:0] word_q;
  logic [6:0]  q_q;
  logic        busy_q;
  logic        done_q;

  logic [7:0]  d_in;
  logic [15:0] word_sh;
  logic [15:0] word_d;
  logic [3:0]  tens_adj;
  logic [3:0]  units_adj;

  assign d_in = {D7, D6, D5, D4, D3, D2, D1, D0};

  // word_q = {bcd[7:0], bin[7:0]}; the BCD LSB falls into the binary MSB.
  assign word_sh = word_q >> 1;

  bcd_digit_adj u_adj_tens (
    .in_i  (word_sh[15:12]),
    .out_o (tens_adj)
  );

  bcd_digit_adj u_adj_units (
    .in_i  (word_sh[11:8]),
    .out_o (units_adj)
  );

  assign word_d = {tens_adj, units_adj, word_sh[7:0]};

`ifdef BCD8_TO_BIN_CHECK_EN
  logic flag_q;
  logic err_q;
`endif

  always_ff @(posedge CLK) begin
    if (CS) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      word_q  <= 16'h0000;
      q_q     <= 7'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD8_TO_BIN_CHECK_EN
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            word_q  <= {d_in, 8'h00};
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef BCD8_TO_BIN_CHECK_EN
            flag_q  <= (d_in[7:4] > MAX_DEC_DIGIT) || (d_in[3:0] > MAX_DEC_DIGIT);
`endif
          end
        end
        SHIFT: begin
          word_q <= word_d;
          cnt_q  <= cnt_q + 3'd1;
          if (cnt_q == ITER_LAST) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef BCD8_TO_BIN_CHECK_EN
            q_q     <= flag_q ? 7'd0 : word_d[6:0];
            err_q   <= flag_q;
`else
            q_q     <= word_d[6:0];
`endif
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {Q6, Q5, Q4, Q3, Q2, Q1, Q0} = q_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
`ifdef BCD8_TO_BIN_CHECK_EN
  assign ERR  = err_q;
`else
  assign ERR  = 1'b0;
`endif

endmodule
